led_chaser_pio: RTL and testbench
=================================

# led_chaser_pio

Avalon-MM slave output peripheral driving a WIDTH-bit LED bank. Software can write the pattern directly, or enable a hardware chase engine that steps the pattern on a programmable prescaler tick. The engine has rotate and bounce modes, and raises a maskable interrupt on every wrap or bounce. The block sits on the Nios II system interconnect in place of the fixed 8-bit output PIO, with zero-wait-state reads.

## Interface
Parameters:
- WIDTH, 8, LED/pattern width, 2..32
- PRESC_W, 24, prescaler counter and PERIOD register width, 1..32
- RESET_PATTERN, 1, DATA value after reset
- RESET_PERIOD, 0, PERIOD value after reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address; unused bits read 0
- out_port  out  WIDTH  LED drive; equals DATA
- irq  out  1  level interrupt, equals STATUS.WRAP & CTRL.IRQEN

## Operation
Register map. A write is `chipselect & ~write_n`; unlisted addresses read 0 and ignore writes.
- 0 DATA (RW): current pattern [WIDTH-1:0].
- 1 CTRL (RW):
  - bit0 RUN: chase enable.
  - bit1 DIR: 0 = toward MSB, 1 = toward LSB.
  - bit2 MODE: 0 = rotate, 1 = bounce.
  - bit3 IRQEN.
- 2 PERIOD (RW): prescaler reload [PRESC_W-1:0].
- 3 STATUS: bit0 WRAP is sticky; writing 1 clears it. bit1 BUSY (read-only) = RUN.
- 4 SET (WO): DATA |= writedata. Reads 0.
- 5 CLR (WO): DATA &= ~writedata. Reads 0.

Prescaler:
- PCNT loads PERIOD on any write to PERIOD, on the RUN 0→1 transition, and after each tick.
- While RUN=1, PCNT decrements each cycle. A tick fires in the cycle PCNT==0.
- PERIOD=N gives one step every N+1 cycles. PERIOD=0 gives a step every cycle.
- While RUN=0, PCNT holds and no ticks fire.

Step on tick:
- Rotate mode:
  - DIR=0 rotates DATA left by 1 (MSB→bit0); DIR=1 rotates right.
  - A step counter SCNT (0..WIDTH-1) increments per step. On SCNT==WIDTH-1 it returns to 0 and sets WRAP.
  - SCNT clears on any write to DATA, SET, CLR or CTRL.
- Bounce mode, DIR=0:
  - If DATA[WIDTH-1]=1, DIR flips to 1, DATA shifts right by 1 (zero fill) and WRAP is set.
  - Otherwise DATA shifts left (zero fill).
- Bounce mode, DIR=1: mirror image of DIR=0, using DATA[0].
- DATA==0 stays 0 in both modes. The prescaler still ticks, but WRAP never sets.

Precedence in a single cycle:
- A software write to DATA, SET or CLR wins over a hardware step. The step is dropped and PCNT reloads.
- A software CTRL write wins over a hardware DIR flip.
- A WRAP set wins over a STATUS write-1-clear in the same cycle.

## Timing
- Reset values:
  - DATA = RESET_PATTERN, so out_port = RESET_PATTERN[WIDTH-1:0].
  - CTRL = 0, PERIOD = RESET_PERIOD, PCNT = RESET_PERIOD, SCNT = 0, WRAP = 0, irq = 0.
- A write takes effect on the clk edge that samples it; out_port reflects it the next cycle.
- Reads have zero wait states; readdata is valid in the same cycle as address.
- First step after RUN 0→1 occurs PERIOD+1 cycles after the CTRL write edge.
- irq rises one cycle after the tick that sets WRAP, and falls one cycle after the clearing write.
- An async reset mid-chase returns every register to its reset value immediately. No step occurs on the edge of reset release.

## Test plan
- Reset with WIDTH=8, RESET_PATTERN=1 → out_port=0x01, readdata at address 1/2/3 = 0, irq=0.
- Write DATA=0x81, SET 0x10, CLR 0x01 → reads of DATA return 0x81, 0x91, 0x90.
- Rotate, PERIOD=3, DATA=0x01, CTRL=0x09:
  - out_port steps 0x02, 0x04 … every 4 cycles.
  - After the 8th step out_port=0x01, WRAP=1, irq=1.
  - Write STATUS=1 → irq=0.
- Bounce, PERIOD=0, DATA=0x40, CTRL=0x05:
  - Sequence is 0x80, then 0x40 with DIR read back as 1 and WRAP set.
  - It then continues down to 0x01, after which DIR=0 and 0x02 follows.
- Collision: with PERIOD=0 running, write DATA=0x55 in a tick cycle → next out_port=0x55 (the step is dropped), then 0xAA one cycle later.
- Assert reset_n mid-chase with irq high → out_port=RESET_PATTERN and irq=0 asynchronously. No step occurs within PERIOD+1 cycles after release, because RUN=0.

Source files
------------

// File: rtl/led_chaser_pio.sv
// Avalon-MM LED output peripheral with a prescaled hardware chase engine
// (rotate / bounce), sticky wrap flag and maskable level interrupt.
module led_chaser_pio #(
  parameter int          WIDTH         = 8,
  parameter int          PRESC_W       = 24,
  parameter logic [31:0] RESET_PATTERN = 32'd1,
  parameter logic [31:0] RESET_PERIOD  = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int                SCNT_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]  RST_DATA   = RESET_PATTERN[WIDTH-1:0];
  localparam logic [PRESC_W-1:0] RST_PERIOD = RESET_PERIOD[PRESC_W-1:0];
  localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(WIDTH - 1);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;

  logic [WIDTH-1:0]   data_q, data_d;
  logic               run_q, run_d;
  logic               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic               irqen_q, irqen_d;
  logic [PRESC_W-1:0] period_q, period_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic               wrap_q, wrap_d;

  logic wr, wr_data, wr_ctrl, wr_period, wr_status, wr_set, wr_clr;
  logic sw_pattern_wr, run_rise, tick, step;

  logic [WIDTH-1:0]  step_data;
  logic              step_dir;
  logic              step_wrap;
  logic [SCNT_W-1:0] step_scnt;

  logic unused_writedata;
  assign unused_writedata = ^writedata;

  always_comb begin
    wr            = chipselect & ~write_n;
    wr_data       = wr & (address == ADDR_DATA);
    wr_ctrl       = wr & (address == ADDR_CTRL);
    wr_period     = wr & (address == ADDR_PERIOD);
    wr_status     = wr & (address == ADDR_STATUS);
    wr_set        = wr & (address == ADDR_SET);
    wr_clr        = wr & (address == ADDR_CLR);
    sw_pattern_wr = wr_data | wr_set | wr_clr;
    run_rise      = wr_ctrl & writedata[0] & ~run_q;
    tick          = run_q & (pcnt_q == '0);
    // An all-zero pattern never moves, so it also never counts or wraps.
    step          = tick & ~sw_pattern_wr & (data_q != '0);
  end

  always_comb begin
    step_data = data_q;
    step_dir  = dir_q;
    step_wrap = 1'b0;
    step_scnt = scnt_q;
    if (!mode_q) begin
      if (dir_q) begin
        step_data = {data_q[0], data_q[WIDTH-1:1]};
      end else begin
        step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end
      if (scnt_q == SCNT_LAST) begin
        step_scnt = '0;
        step_wrap = 1'b1;
      end else begin
        step_scnt = scnt_q + SCNT_W'(1);
      end
    end else if (!dir_q) begin
      if (data_q[WIDTH-1]) begin
        step_data = data_q >> 1;
        step_dir  = 1'b1;
        step_wrap = 1'b1;
      end else begin
        step_data = data_q << 1;
      end
    end else begin
      if (data_q[0]) begin
        step_data = data_q << 1;
        step_dir  = 1'b0;
        step_wrap = 1'b1;
      end else begin
        step_data = data_q >> 1;
      end
    end
  end

  always_comb begin
    data_d = data_q;
    if (wr_data) begin
      data_d = writedata[WIDTH-1:0];
    end else if (wr_set) begin
      data_d = data_q | writedata[WIDTH-1:0];
    end else if (wr_clr) begin
      data_d = data_q & ~writedata[WIDTH-1:0];
    end else if (step) begin
      data_d = step_data;
    end

    run_d   = wr_ctrl ? writedata[0] : run_q;
    mode_d  = wr_ctrl ? writedata[2] : mode_q;
    irqen_d = wr_ctrl ? writedata[3] : irqen_q;
    // Software direction writes override a bounce flip in the same cycle.
    if (wr_ctrl) begin
      dir_d = writedata[1];
    end else if (step) begin
      dir_d = step_dir;
    end else begin
      dir_d = dir_q;
    end

    period_d = wr_period ? writedata[PRESC_W-1:0] : period_q;

    pcnt_d = pcnt_q;
    if (wr_period) begin
      pcnt_d = writedata[PRESC_W-1:0];
    end else if (run_rise || tick) begin
      pcnt_d = period_q;
    end else if (run_q) begin
      pcnt_d = pcnt_q - PRESC_W'(1);
    end

    scnt_d = scnt_q;
    if (sw_pattern_wr || wr_ctrl) begin
      scnt_d = '0;
    end else if (step && !mode_q) begin
      scnt_d = step_scnt;
    end

    // Setting takes priority over a same-cycle write-1-clear.
    wrap_d = wrap_q;
    if (wr_status && writedata[0]) begin
      wrap_d = 1'b0;
    end
    if (step && step_wrap) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RST_DATA;
      run_q    <= 1'b0;
      dir_q    <= 1'b0;
      mode_q   <= 1'b0;
      irqen_q  <= 1'b0;
      period_q <= RST_PERIOD;
      pcnt_q   <= RST_PERIOD;
      scnt_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      irqen_q  <= irqen_d;
      period_q <= period_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]   = data_q;
      ADDR_CTRL:   readdata[3:0]         = {irqen_q, mode_q, dir_q, run_q};
      ADDR_PERIOD: readdata[PRESC_W-1:0] = period_q;
      ADDR_STATUS: readdata[1:0]         = {run_q, wrap_q};
      default:     readdata              = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = wrap_q & irqen_q;

endmodule

// File: tb/tb_led_chaser_pio.sv
// Directed self-checking bench for led_chaser_pio (WIDTH=8, PRESC_W=24,
// RESET_PATTERN=1, RESET_PERIOD=0); inputs change on the falling edge.
module tb_led_chaser_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  int          errors;
  int          checks;
  logic [31:0] rd;

  led_chaser_pio #(
    .WIDTH(8),
    .PRESC_W(24),
    .RESET_PATTERN(32'd1),
    .RESET_PERIOD(32'd0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge; the write is sampled on the next rising edge
  // and the task returns on the falling edge after it.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("[TB] FAIL reset_out_port: got %h expected 01", out_port);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(3'(a), rd);
      checks++;
      if (rd !== ((a == 0) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("[TB] FAIL reset_read_addr%0d: got %h expected %h", a, rd,
                 (a == 0) ? 32'h1 : 32'h0);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_regs;
    logic [31:0] exp_data [3];
    exp_data = '{32'h81, 32'h91, 32'h90};
    bus_write(3'd0, 32'h81);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== exp_data[0]) begin
      errors++;
      $display("[TB] FAIL regs_data_write: got %h expected %h", rd, exp_data[0]);
    end
    bus_write(3'd4, 32'h10);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== exp_data[1]) begin
      errors++;
      $display("[TB] FAIL regs_set: got %h expected %h", rd, exp_data[1]);
    end
    bus_write(3'd5, 32'h01);
    bus_read(3'd0, rd);
    checks++;
    if (rd !== exp_data[2]) begin
      errors++;
      $display("[TB] FAIL regs_clr: got %h expected %h", rd, exp_data[2]);
    end
    bus_write(3'd6, 32'hFF);
    checks++;
    if (out_port !== 8'h90) begin
      errors++;
      $display("[TB] FAIL regs_unmapped_write: got %h expected 90", out_port);
    end
    bus_read(3'd4, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL regs_set_reads0: got %h expected 0", rd);
    end
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, rd);
    checks++;
    if (rd !== 32'h00FF_FFFF) begin
      errors++;
      $display("[TB] FAIL regs_period_width: got %h expected 00ffffff", rd);
    end
  endtask

  task automatic test_rotate;
    logic [7:0] exp_step [8];
    logic [7:0] prev;
    exp_step = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h09);
    prev = 8'h01;
    for (int k = 0; k < 8; k++) begin
      repeat (3) @(negedge clk);
      checks++;
      if (out_port !== prev) begin
        errors++;
        $display("[TB] FAIL rotate_hold%0d: got %h expected %h", k, out_port, prev);
      end
      @(negedge clk);
      checks++;
      if (out_port !== exp_step[k]) begin
        errors++;
        $display("[TB] FAIL rotate_step%0d: got %h expected %h", k, out_port, exp_step[k]);
      end
      prev = exp_step[k];
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rotate_irq_set: got %b expected 1", irq);
    end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("[TB] FAIL rotate_status: got %h expected 3", rd);
    end
    bus_write(3'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rotate_irq_clear: got %b expected 0", irq);
    end
    bus_write(3'd1, 32'h0);
  endtask

  task automatic test_rotate_right;
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h03);
    @(negedge clk);
    checks++;
    if (out_port !== 8'h80) begin
      errors++;
      $display("[TB] FAIL rotr_step1: got %h expected 80", out_port);
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'h40) begin
      errors++;
      $display("[TB] FAIL rotr_step2: got %h expected 40", out_port);
    end
    bus_write(3'd1, 32'h0);
  endtask

  task automatic test_bounce;
    logic [7:0] exp_down [6];
    exp_down = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h40);
    bus_write(3'd1, 32'h05);
    @(negedge clk);
    checks++;
    if (out_port !== 8'h80) begin
      errors++;
      $display("[TB] FAIL bounce_up: got %h expected 80", out_port);
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'h40) begin
      errors++;
      $display("[TB] FAIL bounce_turn: got %h expected 40", out_port);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h7) begin
      errors++;
      $display("[TB] FAIL bounce_dir_flip: got %h expected 7", rd);
    end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'h3) begin
      errors++;
      $display("[TB] FAIL bounce_wrap: got %h expected 3", rd);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_irq_masked: got %b expected 0", irq);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_port !== exp_down[k]) begin
        errors++;
        $display("[TB] FAIL bounce_down%0d: got %h expected %h", k, out_port, exp_down[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'h02) begin
      errors++;
      $display("[TB] FAIL bounce_return: got %h expected 02", out_port);
    end
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++;
      $display("[TB] FAIL bounce_dir_back: got %h expected 5", rd);
    end
    bus_write(3'd1, 32'h0);
    bus_write(3'd3, 32'h1);
  endtask

  task automatic test_back_to_back;
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h55);
    checks++;
    if (out_port !== 8'h55) begin
      errors++;
      $display("[TB] FAIL collision_write_wins: got %h expected 55", out_port);
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL collision_next_step: got %h expected aa", out_port);
    end
    @(negedge clk);
    checks++;
    if (out_port !== 8'h55) begin
      errors++;
      $display("[TB] FAIL collision_step2: got %h expected 55", out_port);
    end
    bus_write(3'd1, 32'h0);
  endtask

  task automatic test_zero_pattern;
    bus_write(3'd3, 32'h1);
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'h0D);
    repeat (20) @(negedge clk);
    checks++;
    if (out_port !== 8'h00 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_stays: got out=%h irq=%b expected out=00 irq=0",
               out_port, irq);
    end
    bus_read(3'd3, rd);
    checks++;
    if (rd !== 32'h2) begin
      errors++;
      $display("[TB] FAIL zero_no_wrap: got %h expected 2", rd);
    end
    bus_write(3'd1, 32'h0);
  endtask

  task automatic test_reset_mid_chase;
    bus_write(3'd2, 32'd0);
    bus_write(3'd0, 32'h01);
    bus_write(3'd1, 32'h09);
    repeat (9) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_irq_before: got %b expected 1", irq);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 8'h01 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got out=%h irq=%b expected out=01 irq=0",
               out_port, irq);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd1, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_ctrl: got %h expected 0", rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("[TB] FAIL midreset_no_step: got %h expected 01", out_port);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_rotate();
    test_rotate_right();
    test_bounce();
    test_back_to_back();
    test_zero_pattern();
    test_reset_mid_chase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
